// File: rtl/cpu_pkg.sv
// Shared constants and types for the LEGv8 register-file read path.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // X31 reads as zero and is never a real write target.
  localparam reg_addr_t XZR = 5'd31;

endpackage

// File: rtl/read_mux32.sv
// One 32:1 operand select from the flattened register file, with X31
// forced to zero regardless of what the register file holds there.
module read_mux32
  import cpu_pkg::*;
(
  input  logic [NREGS*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]       addr,
  output logic [DATA_W-1:0]       data
);

  reg_data_t sel_s;

  // Pick the register whose index matches the requested address.
  always_comb begin
    sel_s = {DATA_W{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      if (addr == reg_addr_t'(i)) begin
        sel_s = regs[i*DATA_W +: DATA_W];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // XZR always reads as zero.
  always_comb begin
    if (addr == XZR) begin
      data = {DATA_W{1'b0}};
    end else begin
      data = sel_s;
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Registered dual read port between decode and ID/EX. Resolves two source
// operands (XZR zero, same-cycle write-back bypass, register file), holds
// them under valid/ready, and keeps a stalled entry coherent with later
// write-backs so execute never sees a stale value.
module reg_read_stage
  import cpu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREGS*DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]       rd_addr1,
  input  logic [ADDR_W-1:0]       rd_addr2,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    wb_we,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    flush,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data1,
  output logic [DATA_W-1:0]       out_data2,
  output logic [ADDR_W-1:0]       out_addr1,
  output logic [ADDR_W-1:0]       out_addr2
);

  reg_data_t mux1_s;
  reg_data_t mux2_s;
  reg_data_t opnd1_s;
  reg_data_t opnd2_s;
  reg_data_t data1_nxt_s;
  reg_data_t data2_nxt_s;
  reg_addr_t addr1_nxt_s;
  reg_addr_t addr2_nxt_s;
  logic      valid_nxt_s;
  logic      wb_live_s;
  logic      load_s;
  logic      hold_s;

  read_mux32 u_mux1 (
    .regs (regs),
    .addr (rd_addr1),
    .data (mux1_s)
  );

  read_mux32 u_mux2 (
    .regs (regs),
    .addr (rd_addr2),
    .data (mux2_s)
  );

  // Handshake: ready whenever the slot is empty or being drained this cycle.
  always_comb begin
    wb_live_s = wb_we && (wb_addr != XZR);
    in_ready  = !out_valid || out_ready;
    load_s    = in_valid && in_ready;
    hold_s    = out_valid && !out_ready;
  end

  // Per-port operand: a live write-back to the same register wins over the
  // register file; XZR never matches because wb_live_s excludes it.
  always_comb begin
    if (wb_live_s && (wb_addr == rd_addr1)) begin
      opnd1_s = wb_data;
    end else begin
      opnd1_s = mux1_s;
    end
    if (wb_live_s && (wb_addr == rd_addr2)) begin
      opnd2_s = wb_data;
    end else begin
      opnd2_s = mux2_s;
    end
  end

  // Next entry contents: capture on load, patch a stalled entry on a
  // matching write-back, otherwise keep what is held.
  always_comb begin
    data1_nxt_s = out_data1;
    data2_nxt_s = out_data2;
    addr1_nxt_s = out_addr1;
    addr2_nxt_s = out_addr2;
    if (load_s) begin
      data1_nxt_s = opnd1_s;
      data2_nxt_s = opnd2_s;
      addr1_nxt_s = rd_addr1;
      addr2_nxt_s = rd_addr2;
    end else if (hold_s && wb_live_s) begin
      if (out_addr1 == wb_addr) begin
        data1_nxt_s = wb_data;
      end else begin
        data1_nxt_s = out_data1;
      end
      if (out_addr2 == wb_addr) begin
        data2_nxt_s = wb_data;
      end else begin
        data2_nxt_s = out_data2;
      end
    end else begin
      data1_nxt_s = out_data1;
      data2_nxt_s = out_data2;
    end
  end

  // Next valid: flush dominates, then load, then consume.
  always_comb begin
    if (flush) begin
      valid_nxt_s = 1'b0;
    end else if (load_s) begin
      valid_nxt_s = 1'b1;
    end else if (out_valid && out_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = out_valid;
    end
  end

  // Output entry registers; reset addresses to XZR so a cleared entry can
  // never be matched by a write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data1 <= {DATA_W{1'b0}};
      out_data2 <= {DATA_W{1'b0}};
      out_addr1 <= XZR;
      out_addr2 <= XZR;
    end else begin
      out_valid <= valid_nxt_s;
      out_data1 <= data1_nxt_s;
      out_data2 <= data2_nxt_s;
      out_addr1 <= addr1_nxt_s;
      out_addr2 <= addr2_nxt_s;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Self-checking bench for reg_read_stage: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// behavioural model of the stage and a bench-owned register file.
module tb_reg_read_stage;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2047:0] regs;
  logic [4:0]    rd_addr1, rd_addr2;
  logic          in_valid;
  logic          in_ready;
  logic          wb_we;
  logic [4:0]    wb_addr;
  logic [63:0]   wb_data;
  logic          flush;
  logic          out_ready;
  logic          out_valid;
  logic [63:0]   out_data1, out_data2;
  logic [4:0]    out_addr1, out_addr2;

  logic [63:0]   rf [32];

  int checks   = 0;
  int failures = 0;

  // Model state: what the stage must be holding.
  logic          ev;
  logic [63:0]   ed1, ed2;
  logic [4:0]    ea1, ea2;

  always #5 clk = ~clk;

  // Present the bench register file on the flattened port.
  always_comb begin
    regs = '0;
    for (int i = 0; i < 32; i++) regs[i*64 +: 64] = rf[i];
  end

  reg_read_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .regs      (regs),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_addr1 (out_addr1),
    .out_addr2 (out_addr2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural read of one source register this cycle.
  function automatic logic [63:0] operand(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return rf[a];
  endfunction

  // Model update at each edge, then compare the DUT a little after it.
  always @(posedge clk) begin : model_cmp
    logic rdy;
    logic ld;
    if (!rst_n) begin
      ev = 1'b0; ed1 = 64'd0; ed2 = 64'd0; ea1 = 5'd31; ea2 = 5'd31;
    end else begin
      rdy = !ev || out_ready;
      ld  = in_valid && rdy;
      if (ld) begin
        ed1 = operand(rd_addr1); ed2 = operand(rd_addr2);
        ea1 = rd_addr1;          ea2 = rd_addr2;
      end else if (ev && !out_ready && wb_we && wb_addr != 5'd31) begin
        if (ea1 == wb_addr) ed1 = wb_data;
        if (ea2 == wb_addr) ed2 = wb_data;
      end
      if (flush)                  ev = 1'b0;
      else if (ld)                ev = 1'b1;
      else if (ev && out_ready)   ev = 1'b0;
    end
    #2;
    chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, !ev || out_ready});
    if (ev) begin
      chk("out_data1", out_data1, ed1);
      chk("out_data2", out_data2, ed2);
      chk("out_addr1", {59'd0, out_addr1}, {59'd0, ea1});
      chk("out_addr2", {59'd0, out_addr2}, {59'd0, ea2});
    end
  end

  // One clock: inputs are held across the edge, then the register file
  // absorbs the write-back at the following falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    if (wb_we && wb_addr != 5'd31) rf[wb_addr] = wb_data;
  endtask

  task automatic rand_inputs();
    rd_addr1  = 5'($urandom_range(0, 31));
    rd_addr2  = ($urandom_range(0, 3) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
    in_valid  = 1'($urandom_range(0, 3) != 0);
    out_ready = 1'($urandom_range(0, 9) < 7);
    flush     = 1'($urandom_range(0, 15) == 0);
    wb_we     = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 4))
      0:       wb_addr = rd_addr1;
      1:       wb_addr = ea1;
      2:       wb_addr = ea2;
      3:       wb_addr = 5'd31;
      default: wb_addr = 5'($urandom_range(0, 31));
    endcase
    wb_data = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0;
    ev = 1'b0; ed1 = 64'd0; ed2 = 64'd0; ea1 = 5'd31; ea2 = 5'd31;
    for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
    rand_inputs();

    // Reset with random activity on the inputs.
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      in_valid = 1'b1;
      cycle();
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_data1", out_data1, 64'd0);
      chk("rst_data2", out_data2, 64'd0);
      chk("rst_addr1", {59'd0, out_addr1}, 64'd31);
      chk("rst_addr2", {59'd0, out_addr2}, 64'd31);
    end
    rst_n = 1'b1;
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
    #1;
    chk("rst_release_ready", {63'd0, in_ready}, 64'd1);
    cycle();

    // Basic read.
    rf[5] = 64'hA5; rf[9] = 64'h3C;
    rd_addr1 = 5'd5; rd_addr2 = 5'd9; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk("basic_valid", {63'd0, out_valid}, 64'd1);
    chk("basic_data1", out_data1, 64'hA5);
    chk("basic_data2", out_data2, 64'h3C);

    // XZR forcing and same-cycle bypass.
    rf[31] = 64'hFFFF; rf[7] = 64'd0;
    rd_addr1 = 5'd31; rd_addr2 = 5'd7;
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 64'h1234;
    cycle();
    chk("xzr_data1", out_data1, 64'd0);
    chk("bypass_data2", out_data2, 64'h1234);

    // Write-back to X31 has no effect.
    rd_addr1 = 5'd31; rd_addr2 = 5'd9;
    wb_we = 1'b1; wb_addr = 5'd31; wb_data = 64'hDEAD;
    cycle();
    chk("wb31_data1", out_data1, 64'd0);
    chk("wb31_data2", out_data2, 64'h3C);

    // Stall coherence.
    wb_we = 1'b0; rf[4] = 64'h44;
    rd_addr1 = 5'd4; rd_addr2 = 5'd9;
    cycle();
    chk("stall_load_data1", out_data1, 64'h44);
    out_ready = 1'b0; in_valid = 1'b1; rd_addr1 = 5'd1;
    for (int k = 0; k < 3; k++) begin
      wb_we = (k == 1); wb_addr = 5'd4; wb_data = 64'hBEEF;
      #1;
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      cycle();
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_addr1", {59'd0, out_addr1}, 64'd4);
      chk("stall_data1", out_data1, (k >= 1) ? 64'hBEEF : 64'h44);
    end

    // Flush while holding, with a request present.
    wb_we = 1'b0; flush = 1'b1; in_valid = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    #1;
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);

    // Back-to-back requests without bubbles.
    for (int i = 1; i <= 4; i++) rf[i] = 64'h100 + 64'(i);
    out_ready = 1'b1; in_valid = 1'b1; rd_addr2 = 5'd31;
    for (int i = 1; i <= 4; i++) begin
      rd_addr1 = 5'(i);
      cycle();
      chk("b2b_valid", {63'd0, out_valid}, 64'd1);
      chk("b2b_data1", out_data1, 64'h100 + 64'(i));
    end
    in_valid = 1'b0;
    cycle();

    // Randomized run with one reset in the middle.
    for (int n = 0; n < 600; n++) begin
      rand_inputs();
      if (n == 300 || n == 301) rst_n = 1'b0;
      else rst_n = 1'b1;
      cycle();
    end
    rst_n = 1'b1;
    in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

- Registered dual read port for the 32 x 64-bit LEGv8 register file.
- Sits between decode and the ID/EX boundary, on the opposite side of the register file from the write-enable decoder.
- Captures two source operands with a 32:1 select per port, forces X31 (XZR) to zero and bypasses a same-cycle write-back.
- Holds operands under a valid/ready handshake and keeps a held entry coherent with later write-backs while downstream stalls.

## Interface
- DATA_W, 64, register data width
- NREGS, 32, register count; address width is log2(NREGS) = 5
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- regs  in  NREGS*DATA_W  flattened register file contents; register i occupies bits [i*DATA_W +: DATA_W]
- rd_addr1, rd_addr2  in  5 each  source register numbers (Rn, Rm)
- in_valid  in  1  decode presents a read request
- in_ready  out  1  stage accepts a request this cycle
- wb_we  in  1  write-back enable (same signal that drives the write decoder)
- wb_addr  in  5  write-back register number
- wb_data  in  DATA_W  write-back data
- flush  in  1  discard held and incoming request (branch mispredict)
- out_ready  in  1  execute stage consumes the output
- out_valid  out  1  operands valid
- out_data1, out_data2  out  DATA_W each  operands
- out_addr1, out_addr2  out  5 each  captured source numbers, used by forwarding logic downstream

## Operation
- Per-port operand, in priority order:
  - addr == 31: data = 0.
  - wb_we && wb_addr == addr && wb_addr != 31: data = wb_data (bypass).
  - Otherwise: data = regs[addr].
- Acceptance:
  - in_ready = !out_valid || out_ready. Combinational; it does not depend on in_valid.
  - load = in_valid && in_ready.
- On load: capture both operands and both addresses; out_valid <= 1.
- Consume without load (out_valid && out_ready && !load): out_valid <= 0. Data and address registers keep their values.
- Hold (out_valid && !out_ready):
  - Held registers keep their values.
  - Exception: on any cycle with wb_we && wb_addr != 31, each held port whose out_addr matches wb_addr updates to wb_data.
  - This keeps stalled operands coherent with the register file.
- flush:
  - out_valid <= 0 next edge, regardless of load, hold or consume.
  - Data and address registers may still load; their contents are don't-care while out_valid = 0.
- Both ports equal (e.g. ADD X3, X5, X5): each port resolves independently and the two produce identical data.
- wb_addr = 31 with wb_we = 1: has no effect on any output.

## Timing
- Latency: 1 cycle. An operand accepted at edge N is visible on out_* after edge N.
- in_ready is combinational from out_valid and out_ready; there is no combinational path from in_valid to in_ready.
- Bypass is combinational from wb_* into the capture registers. wb_data arriving in the same cycle as the request is captured.
- Reset (rst_n low, asynchronous):
  - out_valid = 0.
  - out_data1 = out_data2 = 0.
  - out_addr1 = out_addr2 = 5'd31, so a cleared entry can never match a write-back.
- Reset deasserted mid-handshake: the first edge after release behaves as an empty stage (in_ready = 1).
- Simultaneous events:
  - flush beats load and hold.
  - Write-back update of a held entry and consume in the same cycle: the entry is leaving, so the update is harmless.
  - Load and consume in the same cycle: the new entry replaces the old one. out_valid stays 1.

## Structure
- Shared package `cpu_pkg` holds:
  - DATA_W and NREGS constants
  - XZR = 5'd31
  - typedefs reg_addr_t (logic [4:0]) and reg_data_t (logic [DATA_W-1:0])
- Sub-module `read_mux32`: combinational 32:1 x DATA_W select from regs by address, with the XZR zero forcing. Instantiated once per port.
- Bypass, handshake and held-entry update logic live in the top level.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> out_valid = 0, out_data1/2 = 0, out_addr1/2 = 31; after release, in_ready = 1.
- Basic read: regs[5] = 64'hA5, regs[9] = 64'h3C, rd_addr1 = 5, rd_addr2 = 9, in_valid = 1, out_ready = 1 -> next cycle out_valid = 1, out_data1 = 64'hA5, out_data2 = 64'h3C.
- XZR and bypass:
  - rd_addr1 = 31 with regs[31] = 64'hFFFF -> out_data1 = 0.
  - rd_addr2 = 7, wb_we = 1, wb_addr = 7, wb_data = 64'h1234, regs[7] = 0 -> out_data2 = 64'h1234.
  - wb_addr = 31 with rd_addr1 = 31 -> out_data1 still 0.
- Stall coherence: load with rd_addr1 = 4, then out_ready = 0 for 3 cycles; in cycle 2 drive wb_we = 1, wb_addr = 4, wb_data = 64'hBEEF -> in_ready = 0 throughout the stall, out_data1 = 64'hBEEF from the next cycle, out_valid held at 1.
- Flush: out_valid = 1 and out_ready = 0, assert flush together with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1.
- Back-to-back: in_valid = 1 and out_ready = 1 for 4 consecutive requests to addresses 1, 2, 3, 4 -> out_valid stays 1 and operands appear one per cycle, in order, with no bubble.
